// File: rtl/seq_detect_pkg.sv
// Shared helpers for the parametrised sequence recognizer: KMP prefix/border
// functions evaluated at elaboration time.
package seq_detect_pkg;

  localparam int MAX_N = 32;

  // Bit at time position i (0 = first in time) lives at pattern[n-1-i].
  function automatic int border_len(input logic [MAX_N-1:0] pattern, input int n);
    int   best;
    logic ok;
    best = 0;
    for (int l = 1; l < n; l++) begin
      ok = 1'b1;
      for (int i = 0; i < l; i++) begin
        if (pattern[n-1-i] != pattern[l-1-i]) ok = 1'b0;
      end
      if (ok) best = l;
    end
    return best;
  endfunction

  // Longest proper prefix of the pattern that is a suffix of
  // (first k pattern bits followed by b).
  function automatic int next_prefix(input logic [MAX_N-1:0] pattern, input int n,
                                     input int k, input logic b);
    int   best;
    int   j;
    logic ok;
    logic sb;
    best = 0;
    for (int l = 1; (l <= k + 1) && (l < n); l++) begin
      ok = 1'b1;
      for (int i = 0; i < l; i++) begin
        j  = k + 1 - l + i;
        sb = (j < k) ? pattern[n-1-j] : b;
        if (pattern[n-1-i] != sb) ok = 1'b0;
      end
      if (ok) best = l;
    end
    return best;
  endfunction

endpackage

// File: rtl/seq_detect_param_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          inc,
  input  logic          clr,
  output logic [CW-1:0] cnt
);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != {CW{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/seq_detect_param.sv
// Mealy N-bit pattern recognizer with KMP failure transitions, selectable
// overlapping/non-overlapping matching and a saturating match counter.
module seq_detect_param
  import seq_detect_pkg::*;
#(
  parameter int             N       = 4,
  parameter logic [N-1:0]   PATTERN = 4'b1011,
  parameter int             CW      = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 sd,
  input  logic                 overlap,
  input  logic                 clr_cnt,
  output logic                 pf,
  output logic [CW-1:0]        match_cnt,
  output logic [$clog2(N)-1:0] prefix_len
);

  localparam int             KW      = $clog2(N);
  localparam int             DEPTH   = 1 << KW;
  localparam logic [MAX_N-1:0] PAT_EXT = MAX_N'(PATTERN);
  localparam logic [KW-1:0]  LAST    = KW'(N - 1);
  localparam logic [KW-1:0]  BORDER  = KW'(border_len(PAT_EXT, N));

  if ((N < 2) || (N > MAX_N)) begin : g_bad_n
    $error("seq_detect_param: N must be in 2..32");
  end

  // Next-state tables for sd=0 / sd=1, indexed by the current prefix length.
  logic [KW-1:0] nxt0_tab [DEPTH];
  logic [KW-1:0] nxt1_tab [DEPTH];

  for (genvar g = 0; g < DEPTH; g++) begin : g_tab
    if (g < N) begin : g_live
      assign nxt0_tab[g] = KW'(next_prefix(PAT_EXT, N, g, 1'b0));
      assign nxt1_tab[g] = KW'(next_prefix(PAT_EXT, N, g, 1'b1));
    end else begin : g_pad
      assign nxt0_tab[g] = '0;
      assign nxt1_tab[g] = '0;
    end
  end

  logic [KW-1:0] k_q;
  logic [KW-1:0] k_d;
  logic          completing;

  always_comb begin
    completing = (k_q == LAST) && (sd == PATTERN[0]);
    pf         = rst_n & en & completing;
    k_d        = k_q;
    if (en) begin
      if (completing) begin
        k_d = overlap ? BORDER : '0;
      end else begin
        k_d = sd ? nxt1_tab[k_q] : nxt0_tab[k_q];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) k_q <= '0;
    else        k_q <= k_d;
  end

  assign prefix_len = k_q;

  sat_counter #(.CW(CW)) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (pf),
    .clr   (clr_cnt),
    .cnt   (match_cnt)
  );

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed bench for seq_detect_param: three instances (1011/CW=8, 1111/CW=8,
// 1011/CW=2) sharing one stimulus bus; pf expectations go through a queue.
module tb_seq_detect_param;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic sd = 1'b0;
  logic overlap = 1'b1;
  logic clr_cnt = 1'b0;

  logic       pf_a, pf_b, pf_c;
  logic [7:0] cnt_a, cnt_b;
  logic [1:0] cnt_c;
  logic [1:0] pl_a, pl_b, pl_c;

  int checks = 0;
  int errors = 0;
  logic [0:0] exp_q[$];

  always #5 clk = ~clk;

  seq_detect_param u_a (
    .clk(clk), .rst_n(rst_n), .en(en), .sd(sd), .overlap(overlap),
    .clr_cnt(clr_cnt), .pf(pf_a), .match_cnt(cnt_a), .prefix_len(pl_a)
  );

  seq_detect_param #(.N(4), .PATTERN(4'b1111), .CW(8)) u_b (
    .clk(clk), .rst_n(rst_n), .en(en), .sd(sd), .overlap(overlap),
    .clr_cnt(clr_cnt), .pf(pf_b), .match_cnt(cnt_b), .prefix_len(pl_b)
  );

  seq_detect_param #(.N(4), .PATTERN(4'b1011), .CW(2)) u_c (
    .clk(clk), .rst_n(rst_n), .en(en), .sd(sd), .overlap(overlap),
    .clr_cnt(clr_cnt), .pf(pf_c), .match_cnt(cnt_c), .prefix_len(pl_c)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic pf_of(input int dut);
    case (dut)
      0:       return pf_a;
      1:       return pf_b;
      default: return pf_c;
    endcase
  endfunction

  // Drives one bit at the falling edge, checks the Mealy pf before the rising edge.
  task automatic step(input int dut, input logic en_v, input logic b, input logic exp_pf,
                      input string tag);
    logic [0:0] e;
    @(negedge clk);
    en = en_v;
    sd = b;
    exp_q.push_back(exp_pf);
    #1;
    if (exp_q.size() == 0) begin
      check({tag, "_queue"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check(tag, {31'd0, pf_of(dut)}, {31'd0, e});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    en = 1'b0;
    sd = 1'b0;
    clr_cnt = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  localparam logic [6:0]  S1   = 7'b1011011;
  localparam logic [6:0]  P1OV = 7'b0001001;
  localparam logic [6:0]  P1NO = 7'b0001000;
  localparam logic [7:0]  P3OV = 8'b00011111;
  localparam logic [7:0]  P3NO = 8'b00010001;
  localparam logic [5:0]  S4   = 6'b101011;
  localparam logic [5:0]  P4   = 6'b000001;
  localparam logic [18:0] S6   = 19'b1011011011011011011;
  localparam logic [18:0] P6   = 19'b0001001001001001001;

  initial begin
    int exp_cnt;

    // Reset state, including pf forced low while rst_n=0.
    do_reset();
    check("reset_prefix", {30'd0, pl_a}, 32'd0);
    check("reset_cnt", {24'd0, cnt_a}, 32'd0);

    // 1011, overlapping.
    overlap = 1'b1;
    for (int i = 6; i >= 0; i--) step(0, 1'b1, S1[i], P1OV[i], "t1_pf");
    check("t1_cnt", {24'd0, cnt_a}, 32'd2);
    check("t1_prefix", {30'd0, pl_a}, 32'd1);

    // 1011, non-overlapping.
    do_reset();
    overlap = 1'b0;
    for (int i = 6; i >= 0; i--) step(0, 1'b1, S1[i], P1NO[i], "t2_pf");
    check("t2_cnt", {24'd0, cnt_a}, 32'd1);
    check("t2_prefix", {30'd0, pl_a}, 32'd1);

    // 1111, eight ones, both modes.
    do_reset();
    overlap = 1'b1;
    for (int i = 7; i >= 0; i--) step(1, 1'b1, 1'b1, P3OV[i], "t3_ov_pf");
    check("t3_ov_cnt", {24'd0, cnt_b}, 32'd5);
    do_reset();
    overlap = 1'b0;
    for (int i = 7; i >= 0; i--) step(1, 1'b1, 1'b1, P3NO[i], "t3_no_pf");
    check("t3_no_cnt", {24'd0, cnt_b}, 32'd2);

    // Failure path: 101 then 0 must fall back to prefix 2.
    do_reset();
    overlap = 1'b1;
    for (int i = 5; i >= 0; i--) begin
      step(0, 1'b1, S4[i], P4[i], "t4_pf");
      if (i == 2) check("t4_prefix_fail", {30'd0, pl_a}, 32'd2);
    end
    check("t4_cnt", {24'd0, cnt_a}, 32'd1);

    // en gating: prefix holds through idle cycles, even with sd=1.
    do_reset();
    step(0, 1'b1, 1'b1, 1'b0, "t5_pf");
    step(0, 1'b1, 1'b0, 1'b0, "t5_pf");
    step(0, 1'b1, 1'b1, 1'b0, "t5_pf");
    step(0, 1'b0, 1'b0, 1'b0, "t5_idle_pf");
    step(0, 1'b0, 1'b1, 1'b0, "t5_idle_pf");
    step(0, 1'b0, 1'b0, 1'b0, "t5_idle_pf");
    check("t5_hold_prefix", {30'd0, pl_a}, 32'd3);
    step(0, 1'b1, 1'b1, 1'b1, "t5_resume_pf");
    check("t5_cnt", {24'd0, cnt_a}, 32'd1);

    // Reset mid-pattern discards prefix and count; pf low during reset.
    step(0, 1'b1, 1'b0, 1'b0, "t5b_pf");
    step(0, 1'b1, 1'b1, 1'b0, "t5b_pf");
    check("t5b_prefix_pre", {30'd0, pl_a}, 32'd3);
    @(negedge clk);
    rst_n = 1'b0;
    en = 1'b1;
    sd = 1'b1;
    #1;
    check("t5b_pf_in_reset", {31'd0, pf_a}, 32'd0);
    @(posedge clk);
    #1;
    check("t5b_prefix_reset", {30'd0, pl_a}, 32'd0);
    check("t5b_cnt_reset", {24'd0, cnt_a}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step(0, 1'b1, 1'b1, 1'b0, "t5b_single_pf");
    check("t5b_prefix_after", {30'd0, pl_a}, 32'd1);

    // CW=2 saturation over six back-to-back matches, then clear on a match.
    do_reset();
    overlap = 1'b1;
    exp_cnt = 0;
    for (int i = 18; i >= 0; i--) begin
      step(2, 1'b1, S6[i], P6[i], "t6_pf");
      if (P6[i]) begin
        if (exp_cnt < 3) exp_cnt++;
        check("t6_cnt", {30'd0, cnt_c}, exp_cnt);
      end
    end
    step(2, 1'b1, 1'b0, 1'b0, "t6_pf");
    step(2, 1'b1, 1'b1, 1'b0, "t6_pf");
    clr_cnt = 1'b1;
    step(2, 1'b1, 1'b1, 1'b1, "t6_clr_pf");
    clr_cnt = 1'b0;
    check("t6_clr_cnt", {30'd0, cnt_c}, 32'd0);
    step(2, 1'b1, 1'b0, 1'b0, "t6_pf");
    step(2, 1'b1, 1'b1, 1'b0, "t6_pf");
    step(2, 1'b1, 1'b1, 1'b1, "t6_after_clr_pf");
    check("t6_after_clr_cnt", {30'd0, cnt_c}, 32'd1);

    check("queue_empty", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
